lsu_mem_ctrl: RTL

- Load/store unit between the execute stage and data memory.
- Accepts one load or store at a time and drives a request/ack memory port with byte enables.
- For loads, extracts the byte/halfword/word and sign- or zero-extends it. The result goes on rdata, which is the memory-data input of the 4:1 write-back select mux feeding the register file.
- Provides a bounded-wait timeout and an error flag.

---
 rtl/lsu_mem_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one access at a time over a req/ack memory port, with load extension and ack timeout.
// Optional build macro LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses with err.
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic            st_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic [CW-1:0]   cnt;
    logic            bad_in;
    logic [3:0]      be_in;
    logic [31:0]     wd_in;
    logic            tmo_hit;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;
    logic [31:0]     load_ext;

    // Width check, lane steering and store replication on the incoming request.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        bad_in = 1'b0;
        be_in  = 4'b1111;
        wd_in  = wdata;
        case (funct3)
            3'b000, 3'b001, 3'b010: bad_in = 1'b0;
            3'b100, 3'b101:         bad_in = is_store;
            default:                bad_in = 1'b1;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        if (funct3[1:0] == 2'b01 && addr[0])
            bad_in = 1'b1;
        if (funct3 == 3'b010 && addr[1:0] != 2'b00)
            bad_in = 1'b1;
`endif
        case (funct3[1:0])
            2'b00: begin
                be_in = 4'b0001 << addr[1:0];
                wd_in = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_in = addr[1] ? 4'b1100 : 4'b0011;
                wd_in = {2{wdata[15:0]}};
            end
            default: begin
                be_in = 4'b1111;
                wd_in = wdata;
            end
        endcase
    end

    always_comb begin
        lane_b   = mem_rdata[{off_q, 3'b000} +: 8];
        lane_h   = mem_rdata[{off_q[1], 4'b0000} +: 16];
        load_ext = mem_rdata;
        case (f3_q)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'd0, lane_b};
            3'b101:  load_ext = {16'd0, lane_h};
            default: load_ext = mem_rdata;
        endcase
    end

    // TIMEOUT == 0 disables the bound entirely.
    assign tmo_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ~rst;
                busy      = 1'b0;
                if (req_valid)
                    state_nx = bad_in ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_req = 1'b1;
                mem_we  = st_q;
                if (mem_ack || tmo_hit)
                    state_nx = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nx   = IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // Request capture, memory-bus hold registers and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            cnt       <= '0;
            mem_be    <= 4'b0000;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            rdata     <= 32'd0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        st_q      <= is_store;
                        f3_q      <= funct3;
                        off_q     <= addr[1:0];
                        cnt       <= '0;
                        mem_be    <= be_in;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_wdata <= wd_in;
                        if (bad_in) begin
                            err   <= 1'b1;
                            rdata <= 32'd0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        err   <= 1'b0;
                        rdata <= st_q ? 32'd0 : load_ext;
                    end else if (tmo_hit) begin
                        err   <= 1'b1;
                        rdata <= 32'd0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
